mem_stage_ctrl: RTL
===================

# mem_stage_ctrl

Memory-stage sequencer for the five-stage pipeline. Sits between the EX/MEM pipeline register outputs and a data memory with a req/ack handshake. It issues loads and stores, computes byte enables, and sign- or zero-extends load data. It holds the pipeline with a stall while an access is outstanding, and converts an unanswered access into a sticky bus error after a bounded timeout.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- TIMEOUT_CYCLES, 16, maximum number of wait cycles without ack before error; legal range 1..255.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- MemWriteM  in  1  store in the MEM stage.
- ResultSrcM  in  2  value 2'b01 marks a load in the MEM stage.
- funct3M  in  3  access size and signedness.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data, right-aligned.
- mem_req  out  1  access request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, {ALUResultM[31:2],2'b00}.
- mem_be  out  4  byte-lane enables.
- mem_wdata  out  32  store data replicated or shifted into its lanes.
- mem_ack  in  1  access complete; valid only while mem_req=1.
- mem_rdata  in  32  read word, valid with mem_ack.
- ReadDataM  out  32  extended load result.
- StallM  out  1  freezes PC, IF/ID, ID/EX and EX/MEM.
- KillW  out  1  forces the MEM/WB entry to a bubble (RegWrite=0).
- err_clr  in  1  clears the error state.
- bus_err  out  1  sticky timeout flag.
- stall_cycles  out  32  saturating count of StallM cycles.

## Operation
- memop = MemWriteM | (ResultSrcM==2'b01). When both terms are 1, the access is a store.
- States:
  - IDLE: memop=1 drives mem_req=1 combinationally in the same cycle. If mem_ack is seen in that cycle, the access completes with zero stall. Otherwise next state is WAIT and the counter loads 1.
  - WAIT: mem_req stays 1 and all outputs hold. If mem_ack=1, next state is IDLE. Otherwise, if count==TIMEOUT_CYCLES, next state is ERR. Otherwise count increments.
  - ERR: mem_req=0, bus_err=1, StallM=0. KillW=1 for every memop cycle, so the faulting instruction and any later memory ops retire as bubbles. err_clr=1 returns the FSM to IDLE next cycle.
- StallM = memop & ~mem_ack & (state!=ERR).
- mem_ack arriving while mem_req=0 is ignored.
- Byte enables:
  - SB: 4'b0001<<a[1:0].
  - SH: 4'b0011<<a[1:0], truncated to 4 bits.
  - SW: 4'b1111.
  - Loads use the same rule.
- Store data: SB replicates the byte into all four lanes, SH replicates the halfword into both, SW passes the word through.
- Load data is taken from the enabled lanes of mem_rdata and shifted down.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - ReadDataM is combinational and valid in the ack cycle.
  - ReadDataM is 0 when no load completes in the current cycle.
- stall_cycles increments on each StallM=1 cycle and saturates at 32'hFFFF_FFFF.

## Timing
- Reset (rst=0 at an edge) sets:
  - state IDLE and count 0;
  - bus_err 0 and stall_cycles 0;
  - mem_req 0, StallM 0, KillW 0 and ReadDataM 0 until the next memop.
- Reset in WAIT abandons the access. mem_req is 0 in the first cycle after reset, and a late ack is ignored.
- Latency equals the ack delay: an ack in the request cycle gives 0 stall cycles; an ack N cycles later gives N stall cycles.
- Timeout: with no ack, StallM is high for TIMEOUT_CYCLES+1 cycles, then the FSM enters ERR.
- err_clr together with mem_ack in ERR: err_clr wins and the ack is ignored.
- Back-to-back memops issue with no idle cycle in between.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Misaligned accesses are a halfword with a[0]=1, a word with a[1:0]!=0, or a halfword with a[1:0]==2'b11.
  - These never raise mem_req.
  - KillW pulses for one cycle and the added output misalign_err (1 bit, registered, sticky until err_clr) sets.
  - StallM stays 0 for that access.
- MEM_MISALIGN_TRAP_EN undefined:
  - No check is made and misalign_err is absent.
  - Lanes beyond 3 are dropped; for example SH at a[1:0]=3 gives be=4'b1000.

## Structure
- Shared package mem_ctrl_pkg holds:
  - the state enum (IDLE, WAIT, ERR);
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101;
  - the load encoding RESULT_SRC_MEM=2'b01.
- One sub-module, mem_lane_align, is purely combinational: it computes byte enables, store data placement and load extraction.

## Test plan
- LW at 0x100 with ack in the request cycle, rdata 0xDEADBEEF -> StallM never 1, ReadDataM=0xDEADBEEF, stall_cycles=0.
- LB at 0x103 with ack after 3 cycles, rdata 0x80AABBCC -> StallM high for 3 cycles, be=4'b1000, ReadDataM=0xFFFFFF80. The same access as LBU gives ReadDataM=0x00000080.
- SH of 0x1234 at 0x102 -> mem_we=1, be=4'b1100, mem_wdata=0x12341234.
- No ack with TIMEOUT_CYCLES=4 -> StallM high for 5 cycles, then bus_err=1, mem_req=0, KillW=1. After err_clr, the FSM is back in IDLE.
- rst=0 in WAIT cycle 2, then ack the following cycle -> mem_req=0 after reset, ack ignored, bus_err=0.
- With MEM_MISALIGN_TRAP_EN, LW at 0x101 -> mem_req stays 0, KillW pulses once, misalign_err=1.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory-stage sequencer: FSM states, funct3 access
// codes, the ResultSrc load encoding and the misalignment predicate.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

    // Halfwords must be 2-byte aligned, words 4-byte aligned.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic w_mis;
        w_mis = 1'b0;
        if (f3 == F3_H || f3 == F3_HU)
            w_mis = a[0];
        else if (f3 == F3_W)
            w_mis = (a != 2'b00);
        return w_mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte enables, store-data replication and
// load-data extraction with sign/zero extension.
module mem_lane_align
    import mem_ctrl_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_funct3[1:0])
            2'b00:   o_be = 4'b0001 << i_addr_lo;
            2'b01:   o_be = 4'b0011 << i_addr_lo;
            default: o_be = 4'b1111;
        endcase
    end

    always_comb begin
        case (i_funct3[1:0])
            2'b00:   o_wdata = {4{i_wdata[7:0]}};
            2'b01:   o_wdata = {2{i_wdata[15:0]}};
            default: o_wdata = i_wdata;
        endcase
    end

    // A halfword at offset 3 only has its low lane inside the word.
    always_comb begin
        case (i_addr_lo)
            2'd0:    begin w_byte = i_rdata[7:0];   w_half = i_rdata[15:0];          end
            2'd1:    begin w_byte = i_rdata[15:8];  w_half = i_rdata[23:8];          end
            2'd2:    begin w_byte = i_rdata[23:16]; w_half = i_rdata[31:16];         end
            default: begin w_byte = i_rdata[31:24]; w_half = {8'h00, i_rdata[31:24]}; end
        endcase
    end

    always_comb begin
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_rdata = {24'h000000, w_byte};
            F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
            F3_HU:   o_rdata = {16'h0000, w_half};
            default: o_rdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: req/ack data-memory access with stall, timeout-to-ERR
// and a saturating stall counter. Optional trap: MEM_MISALIGN_TRAP_EN.
module mem_stage_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic [2:0]            funct3M,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallM,
    output logic                  KillW,
    input  logic                  err_clr,
    output logic                  bus_err,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                  misalign_err,
`endif
    output logic [31:0]           stall_cycles
);

    localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);

    state_t      r_state;
    logic [7:0]  r_count;
    logic [31:0] r_stall_cycles;

    logic        w_memop;
    logic        w_is_load;
    logic        w_misalign;
    logic        w_req;
    logic        w_ack;
    logic [31:0] w_load;

    assign w_memop   = MemWriteM | (ResultSrcM == RESULT_SRC_MEM);
    assign w_is_load = ~MemWriteM & (ResultSrcM == RESULT_SRC_MEM);

`ifdef MEM_MISALIGN_TRAP_EN
    logic r_misalign_err;
    assign w_misalign   = (r_state == IDLE) & w_memop & is_misaligned(funct3M, ALUResultM[1:0]);
    assign misalign_err = r_misalign_err;

    always_ff @(posedge clk) begin
        if (!rst)
            r_misalign_err <= 1'b0;
        else if (err_clr)
            r_misalign_err <= 1'b0;
        else if (w_misalign)
            r_misalign_err <= 1'b1;
    end
`else
    assign w_misalign = 1'b0;
`endif

    // Acks are only meaningful while a request is on the bus.
    assign w_req = (r_state == WAIT) | ((r_state == IDLE) & w_memop & ~w_misalign);
    assign w_ack = mem_ack & w_req;

    mem_lane_align u_align (
        .i_funct3  (funct3M),
        .i_addr_lo (ALUResultM[1:0]),
        .i_wdata   (WriteDataM),
        .i_rdata   (mem_rdata),
        .o_be      (mem_be),
        .o_wdata   (mem_wdata),
        .o_rdata   (w_load)
    );

    assign mem_req      = w_req;
    assign mem_we       = w_req & MemWriteM;
    assign mem_addr     = {ALUResultM[31:2], 2'b00};
    assign ReadDataM    = (w_is_load & w_ack) ? w_load : '0;
    assign StallM       = w_memop & ~w_ack & (r_state != ERR) & ~w_misalign;
    assign KillW        = w_memop & ((r_state == ERR) | w_misalign);
    assign bus_err      = (r_state == ERR);
    assign stall_cycles = r_stall_cycles;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req && !w_ack) begin
                        r_state <= WAIT;
                        r_count <= 8'd1;
                    end
                end
                WAIT: begin
                    if (w_ack) begin
                        r_state <= IDLE;
                        r_count <= '0;
                    end else if (r_count == LP_TIMEOUT) begin
                        r_state <= ERR;
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                ERR: begin
                    if (err_clr)
                        r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_stall_cycles <= '0;
        else if (StallM && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + 32'd1;
    end

endmodule
